// File: rtl/raw_rgb_read_sequencer_if.sv
// Signal bundle between the demosaic read sequencer and the video / line-buffer side.
// The master is the sequencer; the slave supplies ENABLE and LINE_RDY and consumes the timing.
interface raw_rgb_read_sequencer_if;
    logic        ENABLE;
    logic        LINE_RDY;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        READ_Request;
    logic [10:0] X_Cont;
    logic [10:0] Y_Cont;
    logic        LINE_REQ;
    logic        FRAME_START;
    logic        UNDERFLOW;

    modport master (
        input  ENABLE, LINE_RDY,
        output VGA_HS, VGA_VS, VGA_BLANK_N, READ_Request,
               X_Cont, Y_Cont, LINE_REQ, FRAME_START, UNDERFLOW
    );

    modport slave (
        output ENABLE, LINE_RDY,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, READ_Request,
               X_Cont, Y_Cont, LINE_REQ, FRAME_START, UNDERFLOW
    );
endinterface

// File: rtl/raw_rgb_read_sequencer.sv
// VGA timing and line-read scheduler for the RAW-to-RGB demosaic path: a line whose
// FIFO data is not ready at its start is blanked whole and flagged, never read short.
module raw_rgb_read_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PREFETCH = 64
) (
    input  logic                             VGA_CLK,
    input  logic                             RST_N,
    raw_rgb_read_sequencer_if.master         bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_M1 = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_REQ    = 11'(H_TOTAL - PREFETCH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        line_ok_q, line_ok_d;
    logic        underflow_q, underflow_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        pix_q, pix_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        req_q, req_d;
    logic        fs_q, fs_d;

    logic running;
    logic h_end;
    logic v_end;
    logic next_active;

    always_comb begin
        running     = (state_q != IDLE);
        h_end       = (h_q == H_LAST);
        v_end       = (v_q == V_LAST);
        // Line 0 only follows the last line if we are not about to drop back to IDLE.
        next_active = (v_q < V_ACT_M1) || (v_end && ((state_q != DRAIN) || bus.ENABLE));

        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        line_ok_d   = line_ok_q;
        underflow_d = underflow_q;

        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (bus.ENABLE) begin
                    state_d     = PRIME;
                    v_d         = V_LAST;
                    underflow_d = 1'b0;
                end
            end
            PRIME: begin
                h_d = h_q + 11'd1;
                if (h_end) begin
                    h_d     = '0;
                    v_d     = '0;
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                h_d = h_q + 11'd1;
                if (h_end) begin
                    h_d = '0;
                    v_d = v_end ? 11'd0 : v_q + 11'd1;
                end
                if (state_q == RUN) begin
                    if (!bus.ENABLE)
                        state_d = DRAIN;
                end else if (bus.ENABLE) begin
                    state_d = RUN;
                end else if (h_end && v_end) begin
                    state_d = IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // FIFO readiness is judged once, at the boundary before the line starts.
        if (running && h_end) begin
            line_ok_d = bus.LINE_RDY;
            if (next_active && !bus.LINE_RDY)
                underflow_d = 1'b1;
        end

        hs_d  = !(running && (h_q >= HS_BEG) && (h_q < HS_END));
        vs_d  = !(running && (v_q >= VS_BEG) && (v_q < VS_END));
        pix_d = running && (h_q < H_ACT) && (v_q < V_ACT) && line_ok_q;
        x_d   = (running && (h_q < H_ACT) && (v_q < V_ACT)) ? h_q : 11'd0;
        y_d   = !running ? 11'd0 : ((v_q < V_ACT) ? v_q : y_q);
        req_d = running && (h_q == H_REQ) &&
                ((v_q < V_ACT_M1) || (v_end && (state_q != DRAIN)));
        fs_d  = pix_d && (h_q == 11'd0) && (v_q == 11'd0);
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            line_ok_q   <= 1'b0;
            underflow_q <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            pix_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            req_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            line_ok_q   <= line_ok_d;
            underflow_q <= underflow_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            pix_q       <= pix_d;
            x_q         <= x_d;
            y_q         <= y_d;
            req_q       <= req_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.VGA_HS       = hs_q;
    assign bus.VGA_VS       = vs_q;
    assign bus.VGA_BLANK_N  = pix_q;
    assign bus.READ_Request = pix_q;
    assign bus.X_Cont       = x_q;
    assign bus.Y_Cont       = y_q;
    assign bus.LINE_REQ     = req_q;
    assign bus.FRAME_START  = fs_q;
    assign bus.UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_raw_rgb_read_sequencer.sv
// Directed bench for raw_rgb_read_sequencer on a shrunken raster: 16/2/4/3 x 8/1/2/2,
// PREFETCH 5, so H_TOTAL=25, V_TOTAL=13 and one frame is 325 cycles.
module tb_raw_rgb_read_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    raw_rgb_read_sequencer_if bus();

    raw_rgb_read_sequencer #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .PREFETCH(5)
    ) dut (
        .VGA_CLK(clk),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    // Counts negedges from the caller's current negedge until the first LINE_REQ and FRAME_START.
    task automatic measure_start(output int lr_at, output int fs_at);
        lr_at = -1;
        fs_at = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.LINE_REQ && lr_at < 0) lr_at = k;
            if (bus.FRAME_START) begin
                fs_at = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        int hs = 0, vs = 0, rd = 0, lr = 0;
        rst_n = 1'b0;
        bus.ENABLE   = 1'b0;
        bus.LINE_RDY = 1'b1;
        repeat (3) @(negedge clk);
        flags = {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.READ_Request,
                 bus.LINE_REQ, bus.FRAME_START, bus.UNDERFLOW};
        checks++; if (flags !== 7'b1100000) begin errors++; $display("[TB] FAIL reset_flags got %b expected %b", flags, 7'b1100000); end
        checks++; if (bus.X_Cont !== 11'd0) begin errors++; $display("[TB] FAIL reset_x got %0d expected 0", bus.X_Cont); end
        checks++; if (bus.Y_Cont !== 11'd0) begin errors++; $display("[TB] FAIL reset_y got %0d expected 0", bus.Y_Cont); end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.VGA_HS) hs++;
            if (!bus.VGA_VS) vs++;
            if (bus.READ_Request) rd++;
            if (bus.LINE_REQ) lr++;
        end
        checks++; if (hs !== 0) begin errors++; $display("[TB] FAIL idle_hs_low got %0d expected 0", hs); end
        checks++; if (vs !== 0) begin errors++; $display("[TB] FAIL idle_vs_low got %0d expected 0", vs); end
        checks++; if (rd !== 0) begin errors++; $display("[TB] FAIL idle_reads got %0d expected 0", rd); end
        checks++; if (lr !== 0) begin errors++; $display("[TB] FAIL idle_line_req got %0d expected 0", lr); end
        checks++; if (bus.UNDERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL idle_underflow got %b expected 0", bus.UNDERFLOW); end
    endtask

    // PRIME spans 25 cycles; the request for line 0 is at h=20 of that line.
    task automatic test_startup();
        int lr_at, fs_at;
        bus.ENABLE = 1'b1;
        measure_start(lr_at, fs_at);
        checks++; if (lr_at !== 22) begin errors++; $display("[TB] FAIL start_line_req_at got %0d expected 22", lr_at); end
        checks++; if (fs_at !== 27) begin errors++; $display("[TB] FAIL start_frame_start_at got %0d expected 27", fs_at); end
        checks++; if (bus.READ_Request !== 1'b1) begin errors++; $display("[TB] FAIL start_read got %b expected 1", bus.READ_Request); end
    endtask

    task automatic test_frame_timing();
        int rd = 0, bl_diff = 0, hs = 0, vs = 0, lr = 0, fs = 0;
        int first_hs = -1, first_vs = -1, first_lr = -1;
        int x5 = -1, y77 = -1, y260 = -1, x280 = -1;
        for (int j = 0; j < 325; j++) begin
            if (bus.READ_Request) rd++;
            if (bus.VGA_BLANK_N !== bus.READ_Request) bl_diff++;
            if (!bus.VGA_HS) begin hs++; if (first_hs < 0) first_hs = j; end
            if (!bus.VGA_VS) begin vs++; if (first_vs < 0) first_vs = j; end
            if (bus.LINE_REQ) begin lr++; if (first_lr < 0) first_lr = j; end
            if (bus.FRAME_START) fs++;
            if (j == 5)   x5   = int'(bus.X_Cont);
            if (j == 77)  y77  = int'(bus.Y_Cont);
            if (j == 260) y260 = int'(bus.Y_Cont);
            if (j == 280) x280 = int'(bus.X_Cont);
            @(negedge clk);
        end
        checks++; if (rd !== 128) begin errors++; $display("[TB] FAIL frame_reads got %0d expected 128", rd); end
        checks++; if (bl_diff !== 0) begin errors++; $display("[TB] FAIL blank_vs_read_diffs got %0d expected 0", bl_diff); end
        checks++; if (hs !== 52) begin errors++; $display("[TB] FAIL frame_hs_low got %0d expected 52", hs); end
        checks++; if (first_hs !== 18) begin errors++; $display("[TB] FAIL hs_first_low got %0d expected 18", first_hs); end
        checks++; if (vs !== 50) begin errors++; $display("[TB] FAIL frame_vs_low got %0d expected 50", vs); end
        checks++; if (first_vs !== 225) begin errors++; $display("[TB] FAIL vs_first_low got %0d expected 225", first_vs); end
        checks++; if (lr !== 8) begin errors++; $display("[TB] FAIL frame_line_req got %0d expected 8", lr); end
        checks++; if (first_lr !== 20) begin errors++; $display("[TB] FAIL line_req_first got %0d expected 20", first_lr); end
        checks++; if (fs !== 1) begin errors++; $display("[TB] FAIL frame_start_count got %0d expected 1", fs); end
        checks++; if (x5 !== 5) begin errors++; $display("[TB] FAIL x_at_h5 got %0d expected 5", x5); end
        checks++; if (y77 !== 3) begin errors++; $display("[TB] FAIL y_line3 got %0d expected 3", y77); end
        checks++; if (y260 !== 7) begin errors++; $display("[TB] FAIL y_held_vblank got %0d expected 7", y260); end
        checks++; if (x280 !== 0) begin errors++; $display("[TB] FAIL x_in_vblank got %0d expected 0", x280); end
        checks++; if (bus.FRAME_START !== 1'b1) begin errors++; $display("[TB] FAIL frame_period got %b expected 1", bus.FRAME_START); end
    endtask

    // LINE_RDY is low only around the boundary that admits line 3.
    task automatic test_underflow();
        int rd3 = 0, bl3 = 0, hs3 = 0, rd4 = 0;
        int uf60 = -1, uf80 = -1, y80 = -1, y100 = -1, x105 = -1;
        for (int j = 0; j < 325; j++) begin
            if (j >= 75 && j < 100) begin
                if (bus.READ_Request) rd3++;
                if (bus.VGA_BLANK_N) bl3++;
                if (!bus.VGA_HS) hs3++;
            end
            if (j >= 100 && j < 125 && bus.READ_Request) rd4++;
            if (j == 60)  uf60 = int'(bus.UNDERFLOW);
            if (j == 80)  begin uf80 = int'(bus.UNDERFLOW); y80 = int'(bus.Y_Cont); end
            if (j == 100) y100 = int'(bus.Y_Cont);
            if (j == 105) x105 = int'(bus.X_Cont);
            bus.LINE_RDY = !(j >= 70 && j <= 76);
            @(negedge clk);
        end
        checks++; if (uf60 !== 0) begin errors++; $display("[TB] FAIL underflow_before got %0d expected 0", uf60); end
        checks++; if (uf80 !== 1) begin errors++; $display("[TB] FAIL underflow_set got %0d expected 1", uf80); end
        checks++; if (rd3 !== 0) begin errors++; $display("[TB] FAIL skipped_line_reads got %0d expected 0", rd3); end
        checks++; if (bl3 !== 0) begin errors++; $display("[TB] FAIL skipped_line_blank got %0d expected 0", bl3); end
        checks++; if (hs3 !== 4) begin errors++; $display("[TB] FAIL skipped_line_hs got %0d expected 4", hs3); end
        checks++; if (y80 !== 3) begin errors++; $display("[TB] FAIL skipped_line_y got %0d expected 3", y80); end
        checks++; if (rd4 !== 16) begin errors++; $display("[TB] FAIL next_line_reads got %0d expected 16", rd4); end
        checks++; if (y100 !== 4) begin errors++; $display("[TB] FAIL next_line_y got %0d expected 4", y100); end
        checks++; if (x105 !== 5) begin errors++; $display("[TB] FAIL next_line_x got %0d expected 5", x105); end
        checks++; if (bus.UNDERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL underflow_sticky got %b expected 1", bus.UNDERFLOW); end
    endtask

    // ENABLE dips and returns (must not disturb timing), then drops for good at line 5.
    task automatic test_drain();
        int rd = 0, lr = 0, fs = 0, hs = 0, vs = 0, late = 0;
        logic [3:0] idle_flags = 4'b0000;
        int idle_y = -1, idle_x = -1;
        for (int j = 0; j < 350; j++) begin
            if (bus.READ_Request) rd++;
            if (bus.LINE_REQ) lr++;
            if (bus.FRAME_START) fs++;
            if (!bus.VGA_HS) hs++;
            if (!bus.VGA_VS) vs++;
            if (j >= 325 && (!bus.VGA_HS || !bus.VGA_VS || bus.LINE_REQ)) late++;
            if (j == 330) begin
                idle_flags = {bus.VGA_HS, bus.VGA_VS, bus.READ_Request, bus.VGA_BLANK_N};
                idle_y = int'(bus.Y_Cont);
                idle_x = int'(bus.X_Cont);
            end
            if (j == 50)  bus.ENABLE = 1'b0;
            if (j == 60)  bus.ENABLE = 1'b1;
            if (j == 125) bus.ENABLE = 1'b0;
            @(negedge clk);
        end
        checks++; if (rd !== 128) begin errors++; $display("[TB] FAIL drain_reads got %0d expected 128", rd); end
        checks++; if (lr !== 7) begin errors++; $display("[TB] FAIL drain_line_req got %0d expected 7", lr); end
        checks++; if (fs !== 1) begin errors++; $display("[TB] FAIL drain_frame_start got %0d expected 1", fs); end
        checks++; if (hs !== 52) begin errors++; $display("[TB] FAIL drain_hs_low got %0d expected 52", hs); end
        checks++; if (vs !== 50) begin errors++; $display("[TB] FAIL drain_vs_low got %0d expected 50", vs); end
        checks++; if (late !== 0) begin errors++; $display("[TB] FAIL after_drain_activity got %0d expected 0", late); end
        checks++; if (idle_flags !== 4'b1100) begin errors++; $display("[TB] FAIL idle_after_drain got %b expected %b", idle_flags, 4'b1100); end
        checks++; if (idle_y !== 0) begin errors++; $display("[TB] FAIL idle_y got %0d expected 0", idle_y); end
        checks++; if (idle_x !== 0) begin errors++; $display("[TB] FAIL idle_x got %0d expected 0", idle_x); end
    endtask

    task automatic test_midframe_reset();
        int lr_at, fs_at;
        logic [6:0] flags;
        checks++; if (bus.UNDERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL underflow_kept_in_idle got %b expected 1", bus.UNDERFLOW); end
        bus.ENABLE = 1'b1;
        measure_start(lr_at, fs_at);
        checks++; if (fs_at !== 27) begin errors++; $display("[TB] FAIL restart_frame_start_at got %0d expected 27", fs_at); end
        checks++; if (bus.UNDERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL underflow_cleared_by_prime got %b expected 0", bus.UNDERFLOW); end
        repeat (62) @(negedge clk);
        checks++; if ({bus.READ_Request, bus.X_Cont, bus.Y_Cont} !== {1'b1, 11'd12, 11'd2}) begin
            errors++; $display("[TB] FAIL pre_reset_pixel got rd=%b x=%0d y=%0d expected rd=1 x=12 y=2", bus.READ_Request, bus.X_Cont, bus.Y_Cont);
        end
        #2 rst_n = 1'b0;
        #1;
        flags = {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.READ_Request,
                 bus.LINE_REQ, bus.FRAME_START, bus.UNDERFLOW};
        checks++; if (flags !== 7'b1100000) begin errors++; $display("[TB] FAIL async_reset_flags got %b expected %b", flags, 7'b1100000); end
        checks++; if ({bus.X_Cont, bus.Y_Cont} !== 22'd0) begin errors++; $display("[TB] FAIL async_reset_xy got x=%0d y=%0d expected 0 0", bus.X_Cont, bus.Y_Cont); end
        @(negedge clk);
        rst_n = 1'b1;
        measure_start(lr_at, fs_at);
        checks++; if (lr_at !== 22) begin errors++; $display("[TB] FAIL reprime_line_req_at got %0d expected 22", lr_at); end
        checks++; if (fs_at !== 27) begin errors++; $display("[TB] FAIL reprime_frame_start_at got %0d expected 27", fs_at); end
    endtask

    initial begin
        bus.ENABLE   = 1'b0;
        bus.LINE_RDY = 1'b1;
        test_reset();
        test_startup();
        test_frame_timing();
        test_underflow();
        test_drain();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
